shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift/rotate unit feeding the ALU result path (Z register input).
//  Takes operand Ra and a shift count from Rb[4:0], then applies the single-step stage
//  once per clock until the count is exhausted. Raises a one-cycle done pulse with
//  the result held on Rz. Lets the control unit sequence SHL/SHR/SHRA/ROL/ROR by N bits.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  CNT_WIDTH   5   shift-count width; count = Rb[CNT_WIDTH-1:0]
// PORTS
//  clock  in   1           single system clock, rising edge
//  clear  in   1           reset: synchronous, active-low (0 = reset on next rising edge)
//  start  in   1           request; sampled only when busy=0
//  op     in   3           000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 reserved
//  Ra     in   DATA_WIDTH  operand to shift
//  Rb     in   DATA_WIDTH  count source; only low CNT_WIDTH bits used
//  Rz     out  DATA_WIDTH  result; valid while done=1, held until next accepted start
//  busy   out  1           high from accept edge until done cycle ends
//  done   out  1           one-cycle completion pulse
// BEHAVIOUR
//  - Reset (clear=0 at edge): state=IDLE, Rz=0, busy=0, done=0, count=0. Overrides everything, incl. mid-operation.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. All outputs registered.
//  - IDLE: start=1 at edge E0 -> latch acc=Ra, cnt=Rb[4:0], op; go SHIFT; busy=1.
//  - SHIFT: per edge, if cnt!=0 then acc=step(acc,op) and cnt=cnt-1; if cnt==0 go DONE, Rz=acc.
//  - DONE: done=1, busy=1 for exactly one cycle; next edge -> IDLE, done=0, busy=0, Rz held.
//  - Latency: done high in the cycle after edge E0+N+1 (N = count). N=0 gives Rz=Ra, done after 1 step cycle.
//  - step: SHL {a[30:0],0}; SHR {0,a[31:1]}; SHRA {a[31],a[31:1]}; ROL {a[30:0],a[31]}; ROR {a[0],a[31:1]}.
//  - Reserved op: no modification; acc passes through unchanged, same latency as a legal op.
//  - start while busy=1 (incl. DONE cycle): ignored; no queueing.
//  - Ra/Rb/op changes after accept: no effect (latched at E0).
//  - Count range 0..31; no modulo beyond CNT_WIDTH. 31 SHRA on negative gives all ones.
// CONFIGURATION
//  - Macro SHIFT_SEQ_FAST_EN:
//      defined: in SHIFT, if cnt>=4 apply 4 steps at once and cnt=cnt-4, else 1 step.
//        Latency = floor(N/4) + (N mod 4) + 1 edges to DONE.
//      undefined: strictly one bit per cycle, latency N+1 as above.
//  - Results are bit-identical in both builds; only timing differs.
// STRUCTURE
//  - Package shift_pkg: op encodings (OP_SHL..OP_ROR), state enum (S_IDLE, S_SHIFT, S_DONE), DATA_WIDTH/CNT_WIDTH defaults.
//  - Sub-module shift_step: combinational single-bit shift/rotate by op, DATA_WIDTH param.
//      FAST build chains four instances for the 4-bit step.
//  - Top: FSM, acc/cnt/op registers, Rz/busy/done registers.
// TESTING
//  1. SHL Ra=0x00000001, Rb=1 -> Rz=0x00000002. Done 2 edges after accept.
//  2. SHL Ra=0x12345678, Rb=4 -> Rz=0x23456780. Latency 5 edges; 2 with SHIFT_SEQ_FAST_EN.
//  3. Right shifts, Rb=31:
//     - SHRA Ra=0x80000000 -> Rz=0xFFFFFFFF.
//     - SHR Ra=0x80000000 -> Rz=0x00000001.
//  4. Rotates, Rb=1:
//     - ROR Ra=0x00000001 -> Rz=0x80000000.
//     - ROL Ra=0x80000000 -> Rz=0x00000001.
//  5. Zero count and busy handling:
//     - Rb=0, Ra=0xDEADBEEF -> Rz=0xDEADBEEF, done 1 edge after accept.
//     - Second start pulsed while busy -> ignored, only one done.
//  6. Reset mid-operation: SHL Rb=20, drive clear=0 at step 5 -> next edge Rz=0, busy=0, done=0.
//     - Then a fresh request SHL Ra=1, Rb=3 -> Rz=0x00000008.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer.
package shift_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_CNT_WIDTH  = 5;
   localparam int unsigned OP_WIDTH           = 3;

   // Operation encodings; 101-111 are reserved and pass the operand through.
   localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_SHRA = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_ROL  = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_ROR  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate stage selected by op; reserved ops pass through.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [OP_WIDTH-1:0]   op,
   output logic [DATA_WIDTH-1:0] y_c
);

   // One-position move of the operand according to op.
   always_comb begin
      y_c = a;
      case (op)
         OP_SHL:  y_c = {a[DATA_WIDTH-2:0], 1'b0};
         OP_SHR:  y_c = {1'b0, a[DATA_WIDTH-1:1]};
         OP_SHRA: y_c = {a[DATA_WIDTH-1], a[DATA_WIDTH-1:1]};
         OP_ROL:  y_c = {a[DATA_WIDTH-2:0], a[DATA_WIDTH-1]};
         OP_ROR:  y_c = {a[0], a[DATA_WIDTH-1:1]};
         default: y_c = a;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: latches Ra, count and op on start, steps the
// accumulator each clock until the count is exhausted, then pulses done with
// the result held on Rz.
// Build option: define SHIFT_SEQ_FAST_EN to retire up to four positions per clock.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] Ra,
   input  logic [DATA_WIDTH-1:0] Rb,
   output logic [DATA_WIDTH-1:0] Rz,
   output logic                  busy,
   output logic                  done
);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic [DATA_WIDTH-1:0] rz_q, rz_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] step1_c;

   // Only the low CNT_WIDTH bits of Rb carry the count.
   logic rb_unused;
   assign rb_unused = ^Rb[DATA_WIDTH-1:CNT_WIDTH];

   shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step1 (.a(acc_q), .op(op_q), .y_c(step1_c));

`ifdef SHIFT_SEQ_FAST_EN
   logic [DATA_WIDTH-1:0] step2_c, step3_c, step4_c;

   // Three more stages chained behind the first give the four-position move.
   shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step2 (.a(step1_c), .op(op_q), .y_c(step2_c));
   shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step3 (.a(step2_c), .op(op_q), .y_c(step3_c));
   shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step4 (.a(step3_c), .op(op_q), .y_c(step4_c));
`endif

   // State and datapath registers with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         rz_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rz_q    <= rz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, datapath update and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rz_d    = rz_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = Ra;
               cnt_d   = Rb[CNT_WIDTH-1:0];
               op_d    = op;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               rz_d    = acc_q;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
`ifdef SHIFT_SEQ_FAST_EN
               if (cnt_q >= CNT_WIDTH'(4)) begin
                  acc_d = step4_c;
                  cnt_d = cnt_q - CNT_WIDTH'(4);
               end else begin
                  acc_d = step1_c;
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
`else
               acc_d = step1_c;
               cnt_d = cnt_q - CNT_WIDTH'(1);
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Rz   = rz_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer using an expected-result queue.
module tb_shift_sequencer;
   import shift_pkg::*;

   localparam int unsigned DW = 32;

   logic          clock = 1'b0;
   logic          clear;
   logic          start;
   logic [2:0]    op;
   logic [DW-1:0] Ra, Rb, Rz;
   logic          busy, done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rz;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   shift_sequencer dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .Ra(Ra), .Rb(Rb), .Rz(Rz), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input int n);
      logic signed [31:0] s;
      s = a;
      case (o)
         OP_SHL:  return a << n;
         OP_SHR:  return a >> n;
         OP_SHRA: return 32'(s >>> n);
         OP_ROL:  return (a << n) | (a >> (32 - n));
         OP_ROR:  return (a >> n) | (a << (32 - n));
         default: return a;
      endcase
   endfunction

   function automatic int latency(input int n);
`ifdef SHIFT_SEQ_FAST_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   // Issue one request, scramble inputs after accept, then wait for done and score it.
   // With poke set, start is held high while busy to show it is ignored.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] rb,
                         input string tag, input bit poke);
      exp_t e;
      logic [31:0] held;
      int   n, k, extra;
      bit   seen;
      n = int'(rb[4:0]);
      e.rz  = model(o, a, n);
      e.lat = latency(n);
      e.tag = tag;
      sb.push_back(e);

      @(negedge clock);
      op = o; Ra = a; Rb = rb; start = 1'b1;
      @(negedge clock);
      start = poke;
      chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
      op = 3'($urandom); Ra = $urandom; Rb = $urandom;

      k = 0; seen = 1'b0;
      while (!seen && k < 200) begin
         @(negedge clock);
         k++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         start = 1'b0;
         return;
      end

      e = sb.pop_front();
      chk({e.tag, "_rz"}, Rz, e.rz);
      chk({e.tag, "_latency"}, 32'(k), 32'(e.lat));
      chk({e.tag, "_busy_done"}, 32'(busy), 32'd1);
      held = Rz;

      @(negedge clock);
      start = 1'b0;
      chk({e.tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({e.tag, "_busy_clear"}, 32'(busy), 32'd0);
      chk({e.tag, "_rz_held"}, Rz, held);

      if (poke) begin
         extra = 0;
         repeat (40) begin
            @(negedge clock);
            if (done || busy) extra++;
         end
         chk({e.tag, "_ignored_start"}, 32'(extra), 32'd0);
      end
   endtask

   initial begin
      clear = 1'b0; start = 1'b0; op = '0; Ra = '0; Rb = '0;
      repeat (2) @(negedge clock);
      chk("reset_rz", Rz, 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      clear = 1'b1;

      run_op(OP_SHL,  32'h0000_0001, 32'd1,  "shl_1",     1'b0);
      run_op(OP_SHL,  32'h1234_5678, 32'd4,  "shl_4",     1'b0);
      run_op(OP_SHRA, 32'h8000_0000, 32'd31, "shra_31",   1'b0);
      run_op(OP_SHR,  32'h8000_0000, 32'd31, "shr_31",    1'b0);
      run_op(OP_ROR,  32'h0000_0001, 32'd1,  "ror_1",     1'b0);
      run_op(OP_ROL,  32'h8000_0000, 32'd1,  "rol_1",     1'b0);
      run_op(OP_SHL,  32'hDEAD_BEEF, 32'd0,  "zero_cnt",  1'b0);
      run_op(OP_ROL,  32'hA5A5_0F0F, 32'd10, "busy_poke", 1'b1);
      run_op(3'd6,    32'hCAFE_F00D, 32'd7,  "reserved",  1'b0);
      run_op(OP_SHR,  32'hFFFF_FFFF, 32'hFFFF_FF25, "rb_high_bits", 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $sformatf("rand%0d", i), 1'b0);
      end

      // Clear in the middle of a long shift must abort it cleanly.
      @(negedge clock);
      op = OP_SHL; Ra = 32'h0000_0001; Rb = 32'd20; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      chk("midop_busy", 32'(busy), 32'd1);
      clear = 1'b0;
      @(negedge clock);
      chk("midreset_rz", Rz, 32'h0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      clear = 1'b1;
      run_op(OP_SHL, 32'h0000_0001, 32'd3, "after_reset", 1'b0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
